// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor with the carry chain split into
// CHUNK-bit pipeline stages (STAGES = WIDTH/CHUNK, latency STAGES, 1 beat/cycle).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    operand handshake (A, B, OP, Cin)
//   OP                    00 A+B, 01 A-B, 10 A+B+Cin, 11 A+~B+Cin
//   out_valid, out_ready  result handshake (S, Cout, Ovf, Zero, Neg)
//   Cout                  carry out of the MSB (for subtract, 1 = no borrow)
//   Ovf                   two's-complement signed overflow
//   Zero, Neg             S == 0, S[WIDTH-1]
module pipelined_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             Neg
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    // Level k holds the inputs of stage k: full operands (only chunks >= k are
    // still consumed), the carry into chunk k and the result chunks below k.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    logic [CHUNK:0]    csum  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic              stall;
    logic              ovf_fin;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            csum[k]  = {1'b0, a_q[k][k*CHUNK +: CHUNK]} + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_q[k]};
            s_nxt[k] = s_q[k];
            s_nxt[k][k*CHUNK +: CHUNK] = csum[k][CHUNK-1:0];
        end
        // b_q already holds the effective (possibly inverted) operand.
        ovf_fin = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                  (s_nxt[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    end

    // Datapath: no reset needed, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (!stall) begin
            a_q[0] <= A;
            b_q[0] <= OP[0] ? ~B : B;
            c_q[0] <= OP[1] ? Cin : OP[0];
            s_q[0] <= '0;
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k+1] <= a_q[k];
                b_q[k+1] <= b_q[k];
                c_q[k+1] <= csum[k][CHUNK];
                s_q[k+1] <= s_nxt[k];
            end
        end
    end

    // Control and registered outputs; the whole pipe freezes while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            Zero      <= 1'b0;
            Neg       <= 1'b0;
        end else if (!stall) begin
            // in_ready is 1 here, so in_valid alone marks an accepted beat.
            v_q[0] <= in_valid;
            for (int k = 0; k < STAGES - 1; k++) begin
                v_q[k+1] <= v_q[k];
            end
            out_valid <= v_q[LAST];
            if (v_q[LAST]) begin
                S    <= s_nxt[LAST];
                Cout <= csum[LAST][CHUNK];
                Ovf  <= ovf_fin;
                Zero <= (s_nxt[LAST] == '0);
                Neg  <= s_nxt[LAST][WIDTH-1];
            end
        end
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined WIDTH-bit adder/subtractor. It is the next generation of the 4-bit ripple adder/subtractor in the ALU datapath. The carry chain is split into CHUNK-bit pipeline stages so wide operands close timing at full clock rate. Adds valid/ready handshake, carry-in modes for multiword chaining, and a status flag set (carry, signed overflow, zero, negative).

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OP  input  2  00 add A+B; 01 sub A-B (A+~B+1); 10 add-with-carry A+B+Cin; 11 sub-with-borrow A+~B+Cin
Cin  input  1  carry-in, used only for OP=10/11
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
S  output  WIDTH  sum/difference, modulo 2^WIDTH
Cout  output  1  carry out of MSB (for subtract: 1 = no borrow)
Ovf  output  1  two's-complement signed overflow
Zero  output  1  S == 0
Neg  output  1  S[WIDTH-1]

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset state: every stage valid bit is 0. out_valid=0, S=0, Cout=0, Ovf=0, Zero=0, Neg=0.
- in_ready is 0 while rst=1. rst overrides all handshakes in the same cycle.
- Transfers: an input is accepted on a rising edge with in_valid && in_ready. An output is consumed on a rising edge with out_valid && out_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !rst && !stall.
  - On stall the whole pipeline holds: all stage registers and valid bits are frozen.
  - Output S and flags stay stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed; they advance with the pipe when not stalled.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES (no stalls). Throughput is 1 beat/cycle. Results leave in acceptance order.
- Effective operand: Beff = (OP[0] ? ~B : B). Carry into chunk 0 is 0 for OP=00, 1 for OP=01, Cin for OP=1x.
- Stage k (0..STAGES-1):
  - Computes bits [k*CHUNK +: CHUNK] from the registered A/Beff chunk and the carry registered by stage k-1.
  - Registers the result chunk, the carry out, and the undelayed upper operand chunks.
  - Lower result chunks are delayed so all chunks align at the output stage.
- Flags are computed in the final stage and registered together with S:
  - Cout = carry out of bit WIDTH-1.
  - Ovf = (A[MSB] == Beff[MSB]) && (S[MSB] != A[MSB]).
  - Zero = (S == 0); Neg = S[MSB].
- No combinational path from A/B/OP/Cin to any output. in_ready depends only on out_valid, out_ready and rst.
- Reset mid-operation: all in-flight beats are discarded, and none emerge after rst deasserts. The first accept after reset behaves as from a clean pipe.
- Simultaneous accept and consume in a cycle with out_valid=1 and out_ready=1: both occur, and the pipe advances.
- Illegal WIDTH/CHUNK combinations are unsupported; benches use legal values only.

Test Plan:
- Default params, OP=00, A=0x0003, B=0x0001 -> 4 cycles after accept: S=0x0004, Cout=0, Ovf=0, Zero=0, Neg=0. Also A=0xFFFF, B=0x0001 -> S=0x0000, Cout=1, Zero=1, Ovf=0.
- OP=01: A=0x0006, B=0x0003 -> S=0x0003, Cout=1. A=0x0001, B=0x0002 -> S=0xFFFF, Cout=0, Neg=1.
- Signed overflow:
  - OP=00, 0x7FFF+0x0001 -> S=0x8000, Ovf=1, Neg=1.
  - OP=01, 0x8000-0x0001 -> S=0x7FFF, Ovf=1, Cout=1.
- Cross-chunk carry and carry modes:
  - OP=00, 0x0FFF+0x0001 -> S=0x1000.
  - OP=10, Cin=1, 0x00FF+0x0000 -> S=0x0100.
  - OP=11, Cin=0, 0x0005-0x0002 -> S=0x0002, Cout=1.
- Backpressure: 8 back-to-back beats (A=i, B=1, OP=00), with out_ready toggled in a pseudo-random pattern:
  - Results are 1..8 in order, with no loss or duplication.
  - S is stable during stalls.
  - in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle at cycle 2 -> out_valid=0 and S=0 after that edge, and none of the 3 results ever appear. A new beat accepted afterwards emerges after 4 cycles.
- Repeat the first and fourth scenarios with WIDTH=8, CHUNK=2: 0xFF+0x01 -> S=0x00, Cout=1, latency 4. WIDTH=32, CHUNK=8: 0x0000FFFF+1 -> 0x00010000.
